// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF measurement sequencer: per response bit it selects an RO pair,
// clears and gates the ripple counters for a fixed window, then compares the two counts.
module ro_puf_sequencer #(
  parameter int NUM_BITS = 8,
  parameter int SEL_W    = 5,
  parameter int CNT_W    = 8,
  parameter int WINDOW   = 256,
  parameter int SETTLE   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SEL_W-1:0]    chal_seed,
  output logic [SEL_W-1:0]    sel_a,
  output logic [SEL_W-1:0]    sel_b,
  output logic                ro_en,
  output logic                cnt_clr,
  output logic                cnt_en,
  input  logic [CNT_W-1:0]    count_a,
  input  logic [CNT_W-1:0]    count_b,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] response,
  output logic                tie_seen
);

  // state   | meaning
  // IDLE    | waiting for start, selects hold their last value
  // CLEAR   | counters cleared, oscillators enabled
  // PRE     | oscillators settle before the count window
  // COUNT   | counters gated for WINDOW cycles
  // POST    | ripple counters settle after gating
  // COMPARE | counts compared, result shifted into response
  // DONE    | one-cycle done pulse

  localparam int K_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int MAX_T = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    PRE     = 3'd2,
    COUNT   = 3'd3,
    POST    = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [TMR_W-1:0] tmr;
  logic [K_W-1:0]   k;
  logic             tmr_done;
  logic             last_bit;

  assign tmr_done = (tmr == '0);
  assign last_bit = (k == K_W'(NUM_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = abort ? IDLE : PRE;
      PRE:     if (abort) state_next = IDLE; else if (tmr_done) state_next = COUNT;
      COUNT:   if (abort) state_next = IDLE; else if (tmr_done) state_next = POST;
      POST:    if (abort) state_next = IDLE; else if (tmr_done) state_next = COMPARE;
      COMPARE: if (abort) state_next = IDLE; else state_next = last_bit ? DONE : CLEAR;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ro_en   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      CLEAR:   begin ro_en = 1'b1; cnt_clr = 1'b1; busy = 1'b1; end
      PRE:     begin ro_en = 1'b1; busy = 1'b1; end
      COUNT:   begin ro_en = 1'b1; cnt_en = 1'b1; busy = 1'b1; end
      POST:    begin ro_en = 1'b1; busy = 1'b1; end
      COMPARE: begin ro_en = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Phase timer is a down-counter loaded on every phase entry; the phase ends at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (state_next != state) begin
      case (state_next)
        PRE:     tmr <= TMR_W'(SETTLE - 1);
        COUNT:   tmr <= TMR_W'(WINDOW - 1);
        POST:    tmr <= TMR_W'(SETTLE - 1);
        default: tmr <= '0;
      endcase
    end else if (!tmr_done) begin
      tmr <= tmr - 1'b1;
    end
  end

  // sel_a/sel_b carry the latched seed plus 2k, so they advance by two per bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_a    <= '0;
      sel_b    <= '0;
      k        <= '0;
      response <= '0;
      tie_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel_a    <= chal_seed;
            sel_b    <= chal_seed + SEL_W'(1);
            k        <= '0;
            response <= '0;
            tie_seen <= 1'b0;
          end
        end
        COMPARE: begin
          if (!abort) begin
            response[k] <= (count_a > count_b);
            if (count_a == count_b) tie_seen <= 1'b1;
            if (!last_bit) begin
              k     <= k + 1'b1;
              sel_a <= sel_a + SEL_W'(2);
              sel_b <= sel_b + SEL_W'(2);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Directed bench for ro_puf_sequencer: a counter model reacts to the RO selects and
// each scenario task checks timing, selects, response and abort/reset behaviour.
module tb_ro_puf_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [4:0] chal_seed;
  logic [4:0] sel_a;
  logic [4:0] sel_b;
  logic       ro_en;
  logic       cnt_clr;
  logic       cnt_en;
  logic [7:0] count_a;
  logic [7:0] count_b;
  logic       busy;
  logic       done;
  logic [7:0] response;
  logic       tie_seen;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;

  always #5 clk = ~clk;

  ro_puf_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .chal_seed (chal_seed),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .ro_en     (ro_en),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .count_a   (count_a),
    .count_b   (count_b),
    .busy      (busy),
    .done      (done),
    .response  (response),
    .tie_seen  (tie_seen)
  );

  // Counter model. Mode 1 (seed 0): even k A wins, odd k B wins, k=3 tie.
  always_comb begin
    count_a = 8'd200;
    count_b = 8'd100;
    if (mode == 1) begin
      if (sel_a[4:1] == 4'd3) begin
        count_a = 8'd77;
        count_b = 8'd77;
      end else if (sel_a[1]) begin
        count_a = 8'd50;
        count_b = 8'd150;
      end
    end
  end

  // Leaves the bench at the first negedge after the accepting edge (state CLEAR).
  task automatic start_run(input logic [4:0] seed);
    @(negedge clk);
    chal_seed = seed;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes one run from the CLEAR cycle; cyc counts cycles since start was raised.
  task automatic watch_run(output int cyc, output int clrs, output int wins, output int bad_wins,
                           output logic [4:0] fa, output logic [4:0] fb,
                           output logic [4:0] sa, output logic [4:0] sb,
                           output logic [4:0] la, output logic [4:0] lb, output bit seen);
    int run;
    run = 0; clrs = 0; wins = 0; bad_wins = 0; seen = 1'b0;
    fa = '0; fb = '0; sa = '0; sb = '0; la = '0; lb = '0;
    cyc = 1;
    while (cyc < 3000) begin
      if (cnt_clr) begin
        if (clrs == 0) begin fa = sel_a; fb = sel_b; end
        else if (clrs == 1) begin sa = sel_a; sb = sel_b; end
        la = sel_a; lb = sel_b;
        clrs++;
      end
      if (cnt_en) run++;
      else if (run != 0) begin
        wins++;
        if (run != 256) bad_wins++;
        run = 0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; chal_seed = 5'd9;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, ro_en, cnt_clr, cnt_en} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, ro_en, cnt_clr, cnt_en});
    end
    n_tests++;
    if ({sel_a, sel_b} !== 10'd0) begin
      n_fail++; $display("FAIL reset_sel got %0d/%0d want 0/0", sel_a, sel_b);
    end
    n_tests++;
    if ({response, tie_seen} !== 9'd0) begin
      n_fail++; $display("FAIL reset_resp got %h/%b want 00/0", response, tie_seen);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || ro_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle got busy=%b ro_en=%b want 0/0", busy, ro_en);
    end
  endtask

  task automatic test_full_run;
    int cyc, clrs, wins, bad; logic [4:0] fa, fb, sa, sb, la, lb; bit seen;
    mode = 0;
    start_run(5'd0);
    n_tests++;
    if (busy !== 1'b1 || cnt_clr !== 1'b1 || ro_en !== 1'b1) begin
      n_fail++; $display("FAIL full_clear got busy=%b clr=%b ro=%b want 1/1/1", busy, cnt_clr, ro_en);
    end
    watch_run(cyc, clrs, wins, bad, fa, fb, sa, sb, la, lb, seen);
    n_tests++;
    if (!seen || cyc != 2129) begin
      n_fail++; $display("FAIL full_latency got %0d (seen=%0b) want 2129", cyc, seen);
    end
    n_tests++;
    if (fa !== 5'd0 || fb !== 5'd1) begin
      n_fail++; $display("FAIL full_first_pair got %0d/%0d want 0/1", fa, fb);
    end
    n_tests++;
    if (la !== 5'd14 || lb !== 5'd15 || clrs != 8) begin
      n_fail++; $display("FAIL full_last_pair got %0d/%0d clrs=%0d want 14/15 8", la, lb, clrs);
    end
    n_tests++;
    if (wins != 8 || bad != 0) begin
      n_fail++; $display("FAIL full_window got wins=%0d bad=%0d want 8/0", wins, bad);
    end
    n_tests++;
    if (response !== 8'hFF || tie_seen !== 1'b0 || busy !== 1'b0 || ro_en !== 1'b0) begin
      n_fail++; $display("FAIL full_result got %h tie=%b busy=%b ro=%b want ff/0/0/0", response, tie_seen, busy, ro_en);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || response !== 8'hFF) begin
      n_fail++; $display("FAIL full_done_pulse got done=%b resp=%h want 0/ff", done, response);
    end
  endtask

  task automatic test_ties;
    int cyc, clrs, wins, bad; logic [4:0] fa, fb, sa, sb, la, lb; bit seen;
    mode = 1;
    start_run(5'd0);
    watch_run(cyc, clrs, wins, bad, fa, fb, sa, sb, la, lb, seen);
    n_tests++;
    if (!seen || cyc != 2129) begin
      n_fail++; $display("FAIL tie_latency got %0d (seen=%0b) want 2129", cyc, seen);
    end
    n_tests++;
    if (response !== 8'h55) begin
      n_fail++; $display("FAIL tie_response got %h want 55", response);
    end
    n_tests++;
    if (tie_seen !== 1'b1) begin
      n_fail++; $display("FAIL tie_sticky got %b want 1", tie_seen);
    end
    mode = 0;
  endtask

  task automatic test_wrap;
    int cyc, clrs, wins, bad; logic [4:0] fa, fb, sa, sb, la, lb; bit seen;
    start_run(5'd31);
    watch_run(cyc, clrs, wins, bad, fa, fb, sa, sb, la, lb, seen);
    n_tests++;
    if (fa !== 5'd31 || fb !== 5'd0) begin
      n_fail++; $display("FAIL wrap_bit0 got %0d/%0d want 31/0", fa, fb);
    end
    n_tests++;
    if (sa !== 5'd1 || sb !== 5'd2) begin
      n_fail++; $display("FAIL wrap_bit1 got %0d/%0d want 1/2", sa, sb);
    end
    n_tests++;
    if (la !== 5'd13 || lb !== 5'd14) begin
      n_fail++; $display("FAIL wrap_bit7 got %0d/%0d want 13/14", la, lb);
    end
    n_tests++;
    if (!seen || cyc != 2129 || response !== 8'hFF) begin
      n_fail++; $display("FAIL wrap_run got cyc=%0d resp=%h want 2129/ff", cyc, response);
    end
    @(negedge clk);
    n_tests++;
    if (sel_a !== 5'd13 || sel_b !== 5'd14) begin
      n_fail++; $display("FAIL wrap_idle_hold got %0d/%0d want 13/14", sel_a, sel_b);
    end
  endtask

  task automatic test_abort;
    int clrs, guard, dones, cyc, wins, bad; logic [4:0] fa, fb, sa, sb, la, lb; bit seen;
    mode = 0;
    start_run(5'd0);
    clrs = 0; guard = 0;
    while (guard < 3000) begin
      if (cnt_clr) clrs++;
      if (clrs == 3 && cnt_en) break;
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (guard >= 3000) begin
      n_fail++; $display("FAIL abort_reach_count got timeout want bit2 COUNT");
    end
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || cnt_en !== 1'b1 || sel_a !== 5'd4 || sel_b !== 5'd5) begin
      n_fail++; $display("FAIL abort_start_ignored got busy=%b en=%b sel=%0d/%0d want 1/1 4/5", busy, cnt_en, sel_a, sel_b);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || ro_en !== 1'b0 || cnt_en !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle got busy=%b ro=%b en=%b done=%b want 0/0/0/0", busy, ro_en, cnt_en, done);
    end
    n_tests++;
    if (response !== 8'h03 || tie_seen !== 1'b0) begin
      n_fail++; $display("FAIL abort_retain got %h tie=%b want 03/0", response, tie_seen);
    end
    dones = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++; $display("FAIL abort_quiet got %0d active cycles want 0", dones);
    end
    start_run(5'd0);
    n_tests++;
    if (response !== 8'h00 || busy !== 1'b1 || sel_a !== 5'd0) begin
      n_fail++; $display("FAIL abort_restart got resp=%h busy=%b sel=%0d want 00/1/0", response, busy, sel_a);
    end
    watch_run(cyc, clrs, wins, bad, fa, fb, sa, sb, la, lb, seen);
    n_tests++;
    if (!seen || cyc != 2129 || response !== 8'hFF) begin
      n_fail++; $display("FAIL abort_rerun got cyc=%0d resp=%h want 2129/ff", cyc, response);
    end
  endtask

  task automatic test_reset_mid_run;
    int falls, guard, cyc, clrs, wins, bad; logic prev; logic [4:0] fa, fb, sa, sb, la, lb; bit seen;
    mode = 1;
    start_run(5'd0);
    falls = 0; guard = 0; prev = 1'b0;
    while (guard < 3000 && falls < 6) begin
      @(negedge clk);
      if (prev && !cnt_en) falls++;
      prev = cnt_en;
      guard++;
    end
    n_tests++;
    if (falls != 6 || ro_en !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_reach_post got falls=%0d ro=%b want 6/1", falls, ro_en);
    end
    rst_n = 1'b0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, done, ro_en, cnt_clr, cnt_en, sel_a, sel_b, response, tie_seen} !== 24'd0) begin
      n_fail++; $display("FAIL midrst_outputs got busy=%b ro=%b sel=%0d/%0d resp=%h tie=%b want all 0",
                         busy, ro_en, sel_a, sel_b, response, tie_seen);
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    mode = 0;
    @(negedge clk);
    start_run(5'd0);
    watch_run(cyc, clrs, wins, bad, fa, fb, sa, sb, la, lb, seen);
    n_tests++;
    if (!seen || cyc != 2129 || response !== 8'hFF || tie_seen !== 1'b0) begin
      n_fail++; $display("FAIL midrst_rerun got cyc=%0d resp=%h tie=%b want 2129/ff/0", cyc, response, tie_seen);
    end
  endtask

  initial begin
    test_reset;
    test_full_run;
    test_ties;
    test_wrap;
    test_abort;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
